// File: rtl/fc_layer.sv
// fc_layer: fully connected classifier stage fed by the serialized pooled
// activations of the second conv/maxpool layer.
//
// One inference is N_IN signed activations, one per i_valid beat. Every beat
// is multiplied by the matching weight of all N_OUT neurons at once and added
// into N_OUT wrapping accumulators. Afterwards the biased sums are streamed
// out one per cycle: shifted right by SHIFT, then saturated to O_BW bits. The
// stream ends with a one-cycle o_done pulse that carries the argmax class.
//
// Ports:
//   clk, global_rst_n  clock, asynchronous active-low reset
//   rst_processEnd     synchronous clear of the whole inference (state, counters,
//                      accumulators, argmax, o_err)
//   i_valid, i_data    input beat strobe and signed activation
//   i_weight           W[j][k] at [(j*N_IN+k)*W_BW +: W_BW]; held stable per inference
//   i_bias             B[j] at [j*B_BW +: B_BW]; held stable per inference
//   o_data, o_index,   saturated neuron output, its neuron index, and the strobe
//   o_valid            for both
//   o_done, o_class    end-of-inference pulse with the argmax index
//   o_busy             high while outputs drain and through the o_done cycle
//   o_err              sticky: a beat arrived while the block could not take it

// One accumulator lane. It exposes the bias-added sum at full precision
// (ACC_BW+1 bits), so the argmax comparison never overflows.
module fc_neuron #(
    parameter int I_BW   = 16,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int ACC_BW = 32
) (
    input  logic                     clk,
    input  logic                     global_rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [I_BW-1:0]   data,
    input  logic signed [W_BW-1:0]   weight,
    input  logic signed [B_BW-1:0]   bias,
    output logic signed [ACC_BW:0]   sum
);
    logic signed [ACC_BW-1:0]      acc;
    logic signed [I_BW+W_BW-1:0]   prod;

    assign prod = data * weight;
    assign sum  = (ACC_BW+1)'(acc) + (ACC_BW+1)'(bias);

    // The accumulator wraps in two's complement and never saturates.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)  acc <= '0;
        else if (clr)       acc <= '0;
        else if (en)        acc <= acc + ACC_BW'(prod);
    end
endmodule

module fc_layer #(
    parameter int I_BW   = 16,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int ACC_BW = 32,
    parameter int O_BW   = 16,
    parameter int N_IN   = 192,
    parameter int N_OUT  = 10,
    parameter int SHIFT  = 8
) (
    input  logic                          clk,
    input  logic                          global_rst_n,
    input  logic                          rst_processEnd,
    input  logic                          i_valid,
    input  logic [I_BW-1:0]               i_data,
    input  logic [N_IN*N_OUT*W_BW-1:0]    i_weight,
    input  logic [N_OUT*B_BW-1:0]         i_bias,
    output logic [O_BW-1:0]               o_data,
    output logic                          o_valid,
    output logic [$clog2(N_OUT)-1:0]      o_index,
    output logic                          o_done,
    output logic [$clog2(N_OUT)-1:0]      o_class,
    output logic                          o_busy,
    output logic                          o_err
);
    localparam int CW = $clog2(N_IN);
    localparam int IW = $clog2(N_OUT);

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic signed [ACC_BW:0] OMAX = (ACC_BW+1)'((64'sd1 <<< (O_BW-1)) - 64'sd1);
    localparam logic signed [ACC_BW:0] OMIN = ~OMAX;

    logic [1:0]                       state;
    logic [CW-1:0]                    in_cnt;
    logic [IW-1:0]                    drain_cnt;
    logic [N_OUT-1:0][W_BW-1:0]       lane_w;
    logic [N_OUT-1:0][ACC_BW:0]       sums;
    logic                             acc_en, acc_clr, last_in, last_out;
    logic signed [ACC_BW:0]           cur, shifted, max_val;
    logic [IW-1:0]                    max_idx;
    logic [O_BW-1:0]                  sat;

    // rst_processEnd wins over a same-cycle beat.
    assign acc_en   = i_valid && (state == ACCUM) && !rst_processEnd;
    assign acc_clr  = rst_processEnd || (state == DONE);
    assign last_in  = (in_cnt == CW'(N_IN - 1));
    assign last_out = (drain_cnt == IW'(N_OUT - 1));

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        assign lane_w[j] = i_weight[(j*N_IN + int'(in_cnt))*W_BW +: W_BW];

        fc_neuron #(
            .I_BW(I_BW), .W_BW(W_BW), .B_BW(B_BW), .ACC_BW(ACC_BW)
        ) u_neuron (
            .clk         (clk),
            .global_rst_n(global_rst_n),
            .clr         (acc_clr),
            .en          (acc_en),
            .data        (i_data),
            .weight      (lane_w[j]),
            .bias        (i_bias[j*B_BW +: B_BW]),
            .sum         (sums[j])
        );
    end

    always_comb begin
        cur     = $signed(sums[drain_cnt]);
        shifted = cur >>> SHIFT;
        if (shifted > OMAX)      sat = OMAX[O_BW-1:0];
        else if (shifted < OMIN) sat = OMIN[O_BW-1:0];
        else                     sat = shifted[O_BW-1:0];
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state     <= ACCUM;
            in_cnt    <= '0;
            drain_cnt <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_index   <= '0;
            o_done    <= 1'b0;
            o_class   <= '0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else if (rst_processEnd) begin
            state     <= ACCUM;
            in_cnt    <= '0;
            drain_cnt <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            if (i_valid && state != ACCUM)
                o_err <= 1'b1;
            case (state)
                ACCUM: begin
                    // o_busy is still high here during the o_done cycle and
                    // drops on the following edge.
                    o_busy <= i_valid && last_in;
                    if (i_valid) begin
                        if (last_in) begin
                            in_cnt <= '0;
                            state  <= DRAIN;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    o_data  <= sat;
                    o_index <= drain_cnt;
                    o_valid <= 1'b1;
                    // Strictly greater keeps the lowest index on ties.
                    if (drain_cnt == '0 || cur > max_val) begin
                        max_val <= cur;
                        max_idx <= drain_cnt;
                    end
                    if (last_out) begin
                        drain_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_done  <= 1'b1;
                    o_class <= max_idx;
                    max_val <= '0;
                    max_idx <= '0;
                    state   <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer. Two instances share all inputs: one with
// SHIFT=0 and one with SHIFT=8. Expected outputs are computed from the bench's
// own copy of data/weights/biases and queued when an inference is driven; the
// monitor pops and compares them as the DUTs stream results.
module tb_fc_layer;
    localparam int I_BW = 16, W_BW = 8, B_BW = 16, ACC_BW = 32, O_BW = 16;
    localparam int N_IN = 192, N_OUT = 10;
    localparam int IW = $clog2(N_OUT);

    typedef struct {
        int val;
        int idx;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        global_rst_n = 1'b1;
    logic                        rst_pe;
    logic                        valid;
    logic [I_BW-1:0]             data;
    logic [N_IN*N_OUT*W_BW-1:0]  weight;
    logic [N_OUT*B_BW-1:0]       bias;

    logic [O_BW-1:0] out_data  [2];
    logic            out_valid [2];
    logic [IW-1:0]   out_index [2];
    logic            out_done  [2];
    logic [IW-1:0]   out_class [2];
    logic            out_busy  [2];
    logic            out_err   [2];

    exp_t q0[$], q1[$];
    int   qc0[$], qc1[$];
    int   wt[N_OUT][N_IN];
    int   bi[N_OUT];
    int   din[N_IN];
    int   cyc = 0, last_edge = 0;
    int   n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer #(.SHIFT(0)) u_dut0 (
        .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_pe),
        .i_valid(valid), .i_data(data), .i_weight(weight), .i_bias(bias),
        .o_data(out_data[0]), .o_valid(out_valid[0]), .o_index(out_index[0]),
        .o_done(out_done[0]), .o_class(out_class[0]), .o_busy(out_busy[0]),
        .o_err(out_err[0])
    );

    fc_layer #(.SHIFT(8)) u_dut1 (
        .clk(clk), .global_rst_n(global_rst_n), .rst_processEnd(rst_pe),
        .i_valid(valid), .i_data(data), .i_weight(weight), .i_bias(bias),
        .o_data(out_data[1]), .o_valid(out_valid[1]), .o_index(out_index[1]),
        .o_done(out_done[1]), .o_class(out_class[1]), .o_busy(out_busy[1]),
        .o_err(out_err[1])
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference model: wrapping 32-bit accumulation, full-precision bias add,
    // arithmetic shift, saturation, first-index argmax.
    task automatic push_expected(input int ncut);
        logic signed [31:0] a;
        longint s, best;
        int cls;
        best = 0;
        cls  = 0;
        for (int j = 0; j < N_OUT; j++) begin
            a = '0;
            for (int k = 0; k < N_IN; k++)
                a = a + 32'(longint'(din[k]) * longint'(wt[j][k]));
            s = longint'(a) + longint'(bi[j]);
            if (j == 0 || s > best) begin
                best = s;
                cls  = j;
            end
            if (j < ncut) begin
                q0.push_back('{int'(clamp(s)), j});
                q1.push_back('{int'(clamp(s >>> 8)), j});
            end
        end
        if (ncut == N_OUT) begin
            qc0.push_back(cls);
            qc1.push_back(cls);
        end
    endtask

    task automatic load_params();
        for (int j = 0; j < N_OUT; j++) begin
            bias[j*B_BW +: B_BW] = 16'(bi[j]);
            for (int k = 0; k < N_IN; k++)
                weight[(j*N_IN + k)*W_BW +: W_BW] = 8'(wt[j][k]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int v);
        data  = 16'(v);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = '0;
    endtask

    // Drives nbeats beats of din with 0..gap_max idle cycles before each;
    // queues the first ncut neuron results (and the class if all are kept).
    task automatic drive_infer(input int gap_max, input int nbeats, input int ncut);
        if (ncut > 0) push_expected(ncut);
        for (int k = 0; k < nbeats; k++) begin
            idle($urandom_range(gap_max, 0));
            beat(din[k]);
        end
        last_edge = cyc;
    endtask

    task automatic finish_infer();
        idle(N_OUT + 6);
        check("busy_after_done", out_busy[0], 0);
    endtask

    task automatic set_ramp();
        for (int j = 0; j < N_OUT; j++) begin
            bi[j] = 0;
            for (int k = 0; k < N_IN; k++) wt[j][k] = j;
        end
        for (int k = 0; k < N_IN; k++) din[k] = 1;
        load_params();
    endtask

    task automatic set_random();
        for (int j = 0; j < N_OUT; j++) begin
            bi[j] = int'($urandom_range(65535, 0)) - 32768;
            for (int k = 0; k < N_IN; k++) wt[j][k] = int'($urandom_range(255, 0)) - 128;
        end
        for (int k = 0; k < N_IN; k++) din[k] = int'($urandom_range(65535, 0)) - 32768;
        load_params();
    endtask

    task automatic pulse_rst_pe();
        rst_pe = 1'b1;
        idle(1);
        rst_pe = 1'b0;
    endtask

    // Scoreboard side: compare every streamed result against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (global_rst_n) begin
            if (out_valid[0]) begin
                if (q0.size() == 0) check("spurious_out0", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("data_s0", $signed(out_data[0]), e.val);
                    check("index_s0", out_index[0], e.idx);
                    check("latency_out", cyc - last_edge, 1 + e.idx);
                end
            end
            if (out_valid[1]) begin
                if (q1.size() == 0) check("spurious_out1", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("data_s8", $signed(out_data[1]), e.val);
                    check("index_s8", out_index[1], e.idx);
                end
            end
            if (out_done[0]) begin
                if (qc0.size() == 0) check("spurious_done0", 1, 0);
                else begin
                    check("class_s0", out_class[0], qc0.pop_front());
                    check("latency_done", cyc - last_edge, N_OUT + 1);
                    check("busy_at_done", out_busy[0], 1);
                end
            end
            if (out_done[1]) begin
                if (qc1.size() == 0) check("spurious_done1", 1, 0);
                else check("class_s8", out_class[1], qc1.pop_front());
            end
        end
    end

    initial begin
        rst_pe = 1'b0;
        valid  = 1'b0;
        data   = '0;
        weight = '0;
        bias   = '0;
        #2 global_rst_n = 1'b0;
        #1;
        check("rst_data", out_data[0], 0);
        check("rst_valid", out_valid[0], 0);
        check("rst_index", out_index[0], 0);
        check("rst_done", out_done[0], 0);
        check("rst_class", out_class[0], 0);
        check("rst_busy", out_busy[0], 0);
        check("rst_err", out_err[0], 0);
        idle(2);
        global_rst_n = 1'b1;
        idle(2);

        // Ramp weights: outputs 192*j, class 9.
        set_ramp();
        drive_infer(0, N_IN, N_OUT);
        check("busy_after_last", out_busy[0], 1);
        finish_infer();
        check("err_ramp", out_err[0], 0);

        // Saturation both ways; all-equal sums tie to class 0.
        for (int j = 0; j < N_OUT; j++)
            for (int k = 0; k < N_IN; k++) wt[j][k] = 127;
        for (int k = 0; k < N_IN; k++) din[k] = 32767;
        load_params();
        drive_infer(0, N_IN, N_OUT);
        finish_infer();
        for (int k = 0; k < N_IN; k++) din[k] = -32768;
        drive_infer(0, N_IN, N_OUT);
        finish_infer();

        // Bias only, tie between indices 1 and 2.
        for (int j = 0; j < N_OUT; j++)
            for (int k = 0; k < N_IN; k++) wt[j][k] = 0;
        bi = '{5, 9, 9, 3, 1, 0, 2, 7, 4, 8};
        for (int k = 0; k < N_IN; k++) din[k] = int'($urandom_range(65535, 0)) - 32768;
        load_params();
        drive_infer(0, N_IN, N_OUT);
        finish_infer();

        // Gapped ramp.
        set_ramp();
        drive_infer(7, N_IN, N_OUT);
        finish_infer();

        // Random signed data, weights and biases.
        set_random();
        drive_infer(2, N_IN, N_OUT);
        finish_infer();

        // rst_processEnd after 100 beats, then a clean ramp inference.
        set_ramp();
        drive_infer(0, 100, 0);
        pulse_rst_pe();
        idle(2);
        drive_infer(0, N_IN, N_OUT);
        finish_infer();

        // rst_processEnd sampled where neuron 4 would be presented.
        drive_infer(0, N_IN, 4);
        idle(4);
        pulse_rst_pe();
        check("abort_valid", out_valid[0], 0);
        idle(N_OUT + 6);
        check("abort_busy", out_busy[0], 0);

        // Overrun: beats during DRAIN are dropped and flag o_err.
        set_random();
        drive_infer(0, N_IN, N_OUT);
        beat(1234);
        beat(-777);
        beat(4321);
        finish_infer();
        check("err_set_s0", out_err[0], 1);
        check("err_set_s8", out_err[1], 1);
        set_ramp();
        drive_infer(1, N_IN, N_OUT);
        finish_infer();
        check("err_sticky", out_err[0], 1);
        pulse_rst_pe();
        check("err_cleared", out_err[0], 0);
        idle(2);

        // Asynchronous reset in the middle of DRAIN.
        drive_infer(0, N_IN, N_OUT);
        idle(3);
        #2 global_rst_n = 1'b0;
        #1;
        check("arst_data", out_data[0], 0);
        check("arst_valid", out_valid[0], 0);
        check("arst_index", out_index[0], 0);
        check("arst_class", out_class[0], 0);
        check("arst_busy", out_busy[0], 0);
        check("arst_data_s8", out_data[1], 0);
        q0.delete();
        q1.delete();
        qc0.delete();
        qc1.delete();
        idle(2);
        global_rst_n = 1'b1;
        idle(2);

        set_random();
        drive_infer(1, N_IN, N_OUT);
        finish_infer();

        check("left_out_s0", q0.size(), 0);
        check("left_out_s8", q1.size(), 0);
        check("left_class", qc0.size() + qc1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
